// File: rtl/fec_cc_encoder.sv
// Tail-biting rate-1/2 K=7 convolutional encoder (G1=171o, G2=133o).
// Ping-pong block buffer: one bank fills while the other encodes.
module fec_cc_encoder #(
    parameter int BLOCK_BITS = 96
) (
    input  logic clk,
    input  logic reset,
    input  logic valid_in,
    input  logic data_in,
    output logic ready_fec,
    output logic valid_out,
    output logic data_out,
    input  logic ready_out,
    output logic block_start,
    output logic block_end
);

    localparam int IW = $clog2(BLOCK_BITS);
    localparam logic [IW-1:0] LAST = IW'(BLOCK_BITS - 1);

    typedef enum logic [1:0] {IDLE, INIT, ENC} state_t;

    state_t state, state_n;

    logic [BLOCK_BITS-1:0] bank [2];
    logic [BLOCK_BITS-1:0] rd_word;
    logic [1:0]    full, full_n;
    logic          wr_bank, wr_bank_n;
    logic          rd_bank, rd_bank_n;
    logic [IW-1:0] wr_idx, wr_idx_n;
    logic [IW-1:0] rd_idx, rd_idx_n;
    logic          phase, phase_n;
    logic [5:0]    s, s_n;
    logic          ready_q;
    logic          wr_en, u, x_bit, y_bit, out_xfer;

    assign wr_en    = valid_in & ready_q;
    assign rd_word  = bank[rd_bank];
    assign u        = rd_word[rd_idx];
    assign x_bit    = u ^ s[0] ^ s[1] ^ s[2] ^ s[5];
    assign y_bit    = u ^ s[1] ^ s[2] ^ s[4] ^ s[5];
    assign out_xfer = valid_out & ready_out;

    assign ready_fec   = ready_q;
    assign valid_out   = (state == ENC);
    assign data_out    = valid_out & (phase ? y_bit : x_bit);
    assign block_start = valid_out & ~phase & (rd_idx == '0);
    assign block_end   = valid_out & phase & (rd_idx == LAST);

    always_ff @(posedge clk) begin
        if (wr_en)
            bank[wr_bank][wr_idx] <= data_in;
    end

    always_comb begin
        state_n   = state;
        full_n    = full;
        wr_bank_n = wr_bank;
        wr_idx_n  = wr_idx;
        rd_bank_n = rd_bank;
        rd_idx_n  = rd_idx;
        phase_n   = phase;
        s_n       = s;

        if (wr_en) begin
            if (wr_idx == LAST) begin
                full_n[wr_bank] = 1'b1;
                wr_bank_n       = ~wr_bank;
                wr_idx_n        = '0;
            end else begin
                wr_idx_n = wr_idx + 1'b1;
            end
        end

        unique case (state)
            IDLE: begin
                if (full[rd_bank])
                    state_n = INIT;
            end
            INIT: begin
                // Tail-biting: start in the state the block's last 6 bits leave
                s_n = {rd_word[BLOCK_BITS-6], rd_word[BLOCK_BITS-5],
                       rd_word[BLOCK_BITS-4], rd_word[BLOCK_BITS-3],
                       rd_word[BLOCK_BITS-2], rd_word[BLOCK_BITS-1]};
                rd_idx_n = '0;
                phase_n  = 1'b0;
                state_n  = ENC;
            end
            ENC: begin
                if (out_xfer) begin
                    if (!phase) begin
                        phase_n = 1'b1;
                    end else begin
                        phase_n = 1'b0;
                        s_n     = {s[4:0], u};
                        if (rd_idx == LAST) begin
                            full_n[rd_bank] = 1'b0;
                            rd_bank_n       = ~rd_bank;
                            state_n = full_n[~rd_bank] ? INIT : IDLE;
                        end else begin
                            rd_idx_n = rd_idx + 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_idx  <= '0;
            rd_idx  <= '0;
            phase   <= 1'b0;
            s       <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_n;
            full    <= full_n;
            wr_bank <= wr_bank_n;
            rd_bank <= rd_bank_n;
            wr_idx  <= wr_idx_n;
            rd_idx  <= rd_idx_n;
            phase   <= phase_n;
            s       <= s_n;
            ready_q <= ~full_n[wr_bank_n];
        end
    end

endmodule

// File: tb/tb_fec_cc_encoder.sv
// Bench for fec_cc_encoder: vector table, random handshakes,
// tail-biting reference model, back-to-back and reset sequences.
module tb_fec_cc_encoder;

    localparam int N  = 96;
    localparam int NO = 2 * N;

    logic clk = 1'b0;
    logic reset, valid_in, data_in, ready_out;
    logic ready_fec, valid_out, data_out, block_start, block_end;

    int n_cmp = 0;
    int n_bad = 0;
    bit abort = 1'b0;

    logic [N-1:0]  in_q  [$];
    logic [NO-1:0] exp_q [$];

    typedef struct {
        logic [N-1:0]  din;
        int            vpct;
        int            rpct;
        logic [NO-1:0] dout;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    fec_cc_encoder #(.BLOCK_BITS(N)) dut (
        .clk(clk), .reset(reset),
        .valid_in(valid_in), .data_in(data_in), .ready_fec(ready_fec),
        .valid_out(valid_out), .data_out(data_out), .ready_out(ready_out),
        .block_start(block_start), .block_end(block_end)
    );

    // Each coded pair from a circular window over the block; bit 0 = MSB
    function automatic logic [NO-1:0] cc_ref(input logic [N-1:0] blk);
        logic [6:0] g1;
        logic [6:0] g2;
        logic [NO-1:0] res;
        logic x, y, b;
        g1 = 7'o171;
        g2 = 7'o133;
        res = '0;
        for (int i = 0; i < N; i++) begin
            x = 1'b0;
            y = 1'b0;
            for (int d = 0; d < 7; d++) begin
                b = blk[N - 1 - ((i - d + N) % N)];
                if (g1[6-d]) x ^= b;
                if (g2[6-d]) y ^= b;
            end
            res[NO-1-2*i] = x;
            res[NO-2-2*i] = y;
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [NO-1:0] act,
                         input logic [NO-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int vpct);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        while ($urandom_range(99) >= vpct) begin
            valid_in = 1'b0;
            data_in  = 1'($urandom);
            @(posedge clk); #1;
        end
        valid_in = 1'b1;
        data_in  = b;
        do begin
            acc = ready_fec;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 2000);
        valid_in = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            abort = 1'b1;
            $display("FAIL in_timeout: ready_fec stuck low for %0d cycles", n);
        end
    endtask

    task automatic feeder(input int vpct, input bit b2b);
        logic [N-1:0] blk;
        int acc_bits;
        acc_bits = 0;
        while (in_q.size() > 0 && !abort) begin
            blk = in_q.pop_front();
            for (int i = 0; i < N && !abort; i++) begin
                send_bit(blk[N-1-i], vpct);
                acc_bits++;
                if (b2b && acc_bits == 2 * N)
                    check("ready_drop", NO'(ready_fec), NO'(0));
            end
        end
    endtask

    task automatic collector(input int nblk, input int rpct, input bit gap_chk);
        logic [NO-1:0] exp, got;
        int k, cyc, ferr, serr, idle;
        bit stalled;
        logic pd;
        for (int b = 0; b < nblk; b++) begin
            exp = exp_q.pop_front();
            got = '0;
            k = 0; cyc = 0; ferr = 0; serr = 0; idle = 0;
            stalled = 1'b0;
            pd = 1'b0;
            while (k < NO && cyc < 5000 && !abort) begin
                ready_out = ($urandom_range(99) < rpct);
                if (valid_out) begin
                    if (stalled && data_out !== pd) serr++;
                    if (block_start !== (k == 0)) ferr++;
                    if (block_end !== (k == NO - 1)) ferr++;
                    pd = data_out;
                    stalled = !ready_out;
                    if (ready_out) begin
                        got = {got[NO-2:0], data_out};
                        k++;
                    end
                end else begin
                    if (block_start || block_end) ferr++;
                    if (stalled) serr++;
                    stalled = 1'b0;
                    if (k == 0) idle++;
                end
                @(posedge clk); #1;
                cyc++;
            end
            if (k < NO) begin
                n_cmp++;
                n_bad++;
                abort = 1'b1;
                $display("FAIL out_timeout: blk %0d got %0d of %0d bits", b, k, NO);
            end
            check($sformatf("coded_blk%0d", b), got, exp);
            check($sformatf("flags_blk%0d", b), NO'(ferr), NO'(0));
            check($sformatf("stall_blk%0d", b), NO'(serr), NO'(0));
            if (gap_chk && b > 0)
                check($sformatf("gap_blk%0d", b), NO'(idle), NO'(1));
        end
    endtask

    task automatic run(input int nblk, input int vpct, input int rpct, input bit b2b);
        fork
            feeder(vpct, b2b);
            collector(nblk, rpct, b2b);
        join
        ready_out = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0]  vec_in;
        logic [NO-1:0] vec_out;
        int w;

        vec_in  = 96'h558AC4A53A1724E163AC2BF9;
        vec_out = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;

        tbl[0] = '{vec_in, 100, 100, vec_out};
        tbl[1] = '{vec_in, 100, 70, vec_out};
        tbl[2] = '{vec_in, 50, 100, vec_out};
        tbl[3] = '{{N{1'b1}}, 100, 100, {NO{1'b1}}};
        tbl[4] = '{{{(N-1){1'b0}}, 1'b1}, 100, 100, {12'hBC7, 178'b0, 2'b11}};
        tbl[5] = '{{N{1'b0}}, 60, 80, {NO{1'b0}}};
        for (int i = 6; i < 8; i++) begin
            tbl[i].din  = {$urandom, $urandom, $urandom};
            tbl[i].vpct = 50;
            tbl[i].rpct = 70;
            tbl[i].dout = cc_ref(tbl[i].din);
        end

        reset = 1'b0;
        valid_in = 1'b0;
        data_in = 1'b0;
        ready_out = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", NO'({ready_fec, valid_out, data_out, block_start, block_end}), NO'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", NO'(ready_fec), NO'(1));

        for (int i = 0; i < 8; i++) begin
            in_q.push_back(tbl[i].din);
            exp_q.push_back(tbl[i].dout);
            run(1, tbl[i].vpct, tbl[i].rpct, 1'b0);
        end

        for (int i = 0; i < 5; i++) begin
            in_q.push_back(vec_in);
            exp_q.push_back(vec_out);
        end
        run(5, 100, 100, 1'b1);

        for (int i = 0; i < 3; i++) begin
            in_q.push_back(tbl[6].din);
            exp_q.push_back(cc_ref(tbl[6].din));
        end
        run(3, 40, 60, 1'b0);

        for (int i = 0; i < 50; i++)
            send_bit(1'($urandom), 100);
        reset = 1'b0;
        #1;
        check("rst_mid_fill", NO'({ready_fec, valid_out, data_out}), NO'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst1", NO'(ready_fec), NO'(1));

        ready_out = 1'b1;
        for (int i = 0; i < N; i++)
            send_bit(1'($urandom), 100);
        w = 0;
        while (!valid_out && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("enc_started", NO'(valid_out), NO'(1));
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_mid_enc", NO'({valid_out, data_out, block_start, block_end}), NO'(0));
        ready_out = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst2", NO'(ready_fec), NO'(1));

        in_q.push_back(vec_in);
        exp_q.push_back(vec_out);
        run(1, 100, 100, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
